// File: rtl/tmr_vote_sequencer.sv
// tmr_vote_sequencer
//   Bit-serial 2-of-3 majority voter for triple-redundant words. One vote
//   cell is reused across the word, LSB first, one bit per clock. The voted
//   word, a per-replica disagreement summary and sticky per-replica fault
//   flags are produced. Fault flags come from consecutive-bad-word counters.
//
//   Parameters
//     WIDTH        word width, >=1 (one vote cycle per bit)
//     FAULT_LIMIT  consecutive mismatching words before a fault sets, >=1
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   A/B/C triple handshake (ready only in IDLE)
//     A, B, C             replica words 0/1/2
//     out_valid/out_ready result handshake (valid only in DONE)
//     Y                   voted word
//     mismatch[2:0]       replica disagreed on >=1 bit of this word
//     fault[2:0]          sticky per-replica fault
//     busy                not IDLE
//     err_count[15:0]     only with TMR_ERR_CNT_EN: saturating count of
//                         vote cycles with any disagreement
//
//   Build option: define TMR_ERR_CNT_EN to add err_count.

// Consecutive-bad-word tracker for one replica.
module tmr_fault_track #(
  parameter int FAULT_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic bad,
  output logic fault
);
  localparam int CW = $clog2(FAULT_LIMIT + 1);

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = '0;
    if (bad) cnt_nxt = (cnt == CW'(FAULT_LIMIT)) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      fault <= 1'b0;
    end else if (upd) begin
      cnt <= cnt_nxt;
      if (cnt_nxt == CW'(FAULT_LIMIT)) fault <= 1'b1;
    end
  end
endmodule

module tmr_vote_sequencer #(
  parameter int WIDTH       = 8,
  parameter int FAULT_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [2:0]       mismatch,
  output logic [2:0]       fault,
  output logic             busy
`ifdef TMR_ERR_CNT_EN
  ,
  output logic [15:0]      err_count
`endif
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, VOTE, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a, sh_b, sh_c;
  logic [IW-1:0]    bit_idx;
  logic             maj, last, accept, vote_en;
  logic [2:0]       bit_mm, mm_fin;
  logic [WIDTH:0]   y_cat;

  // Single majority cell on the current LSBs.
  assign maj    = (sh_a[0] & sh_b[0]) | (sh_b[0] & sh_c[0]) | (sh_c[0] & sh_a[0]);
  assign bit_mm = {sh_c[0] ^ maj, sh_b[0] ^ maj, sh_a[0] ^ maj};
  assign mm_fin = mismatch | bit_mm;
  assign last   = (bit_idx == IW'(WIDTH - 1));
  // New vote enters at the MSB; concatenate-then-drop works for WIDTH=1 too.
  assign y_cat  = {maj, Y};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    vote_en   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = VOTE;
        end
      end
      VOTE: begin
        vote_en = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_c     <= '0;
      bit_idx  <= '0;
      Y        <= '0;
      mismatch <= '0;
    end else if (accept) begin
      sh_a     <= A;
      sh_b     <= B;
      sh_c     <= C;
      bit_idx  <= '0;
      mismatch <= '0;
    end else if (vote_en) begin
      sh_a     <= sh_a >> 1;
      sh_b     <= sh_b >> 1;
      sh_c     <= sh_c >> 1;
      bit_idx  <= bit_idx + IW'(1);
      Y        <= y_cat[WIDTH:1];
      mismatch <= mm_fin;
    end
  end

  // Counters see the final word summary on the edge that enters DONE.
  for (genvar i = 0; i < 3; i++) begin : g_trk
    tmr_fault_track #(.FAULT_LIMIT(FAULT_LIMIT)) u_trk (
      .clk  (clk),
      .rst  (rst),
      .upd  (vote_en & last),
      .bad  (mm_fin[i]),
      .fault(fault[i])
    );
  end

`ifdef TMR_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (vote_en && (|bit_mm) && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`endif
endmodule
